// File: rtl/fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared definitions for the instruction fetch controller:
//   - RESET_PC_DEFAULT : default first fetch address after reset
//   - fetch_state_t    : fetch FSM states
//   - ibus_req_t       : instruction bus request  (valid, addr)
//   - ibus_resp_t      : instruction bus response (addr_ok, data_ok, data)
//   - sat_inc64        : saturating 64-bit increment used by the counters
// ---------------------------------------------------------------------------
package fetch_ctrl_pkg;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2,
    HOLD    = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  function automatic logic [63:0] sat_inc64(input logic [63:0] v);
    return (&v) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_if
// Instruction bus between the fetch controller and the memory side.
//   ireq  : request  (valid, addr), driven by the master (fetch_ctrl)
//   iresp : response (addr_ok, data_ok, data), driven by the slave (memory)
// Modports: master (fetch side), slave (memory side).
// ---------------------------------------------------------------------------
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  ibus_req_t  ireq;
  ibus_resp_t iresp;

  modport master (output ireq, input  iresp);
  modport slave  (input  ireq, output iresp);

endinterface

// File: rtl/fetch_perf.sv
// ---------------------------------------------------------------------------
// fetch_perf
// Saturating performance counters for the fetch controller.
//   clk, reset    : core clock, asynchronous active-low reset
//   i_inc_fetch   : one instruction captured into the fetch buffer
//   i_inc_wait    : one cycle spent waiting for data_ok
//   o_fetch_cnt   : instructions fetched (saturates at all-ones)
//   o_wait_cnt    : wait cycles (saturates at all-ones)
// Only instantiated when FETCH_PERF_EN is defined.
// ---------------------------------------------------------------------------
module fetch_perf
  import fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_inc_fetch,
  input  logic        i_inc_wait,
  output logic [63:0] o_fetch_cnt,
  output logic [63:0] o_wait_cnt
);

  logic [63:0] r_fetch_cnt;
  logic [63:0] r_wait_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      if (i_inc_fetch) r_fetch_cnt <= sat_inc64(r_fetch_cnt);
      if (i_inc_wait)  r_wait_cnt  <= sat_inc64(r_wait_cnt);
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
  assign o_wait_cnt  = r_wait_cnt;

endmodule

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Single-outstanding instruction fetch controller with a one-entry buffer.
//   clk            : core clock, rising edge
//   reset          : asynchronous active-low reset
//   ibus           : instruction bus (fetch_ctrl_if.master: ireq out, iresp in)
//   stall          : decode not ready, buffered instruction kept
//   redirect_valid : single-cycle redirect pulse from execute
//   redirect_pc    : redirect target (4-byte aligned)
//   f_valid        : f_pc/f_instr hold a valid instruction
//   f_pc, f_instr  : buffered instruction and its PC
//   perf_fetch_cnt, perf_wait_cnt : only present with FETCH_PERF_EN
// Optional feature macro: FETCH_PERF_EN (performance counters).
// ---------------------------------------------------------------------------
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  fetch_ctrl_if.master ibus,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        f_valid,
  output logic [63:0] f_pc,
  output logic [31:0] f_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_wait_cnt
`endif
);

  fetch_state_t r_state, w_state_nxt;
  logic [63:0]  r_pc, w_pc_nxt;
  // Address of the request on the bus; stays put in DISCARD while r_pc
  // already tracks the redirect target.
  logic [63:0]  r_addr, w_addr_nxt;
  logic [63:0]  r_buf_pc;
  logic [31:0]  r_buf_instr;
  logic         w_capture;
  logic         w_data_ok;
  logic         w_unused_addr_ok;

  assign w_data_ok = ibus.iresp.data_ok;
  // The request is held until data_ok, so addr_ok carries no extra meaning.
  assign w_unused_addr_ok = ibus.iresp.addr_ok;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_addr_nxt  = r_addr;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nxt = FETCH;
        w_addr_nxt  = r_pc;
      end
      FETCH: begin
        if (w_data_ok) begin
          if (redirect_valid) begin
            // Response lands with a redirect: drop it and refetch at once.
            w_pc_nxt    = redirect_pc;
            w_addr_nxt  = redirect_pc;
            w_state_nxt = FETCH;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = HOLD;
          end
        end else if (redirect_valid) begin
          w_pc_nxt    = redirect_pc;
          w_state_nxt = DISCARD;
        end
      end
      DISCARD: begin
        if (redirect_valid) w_pc_nxt = redirect_pc;
        if (w_data_ok) begin
          w_state_nxt = FETCH;
          w_addr_nxt  = w_pc_nxt;
        end
      end
      HOLD: begin
        // Redirect wins over consume, regardless of stall.
        if (redirect_valid) begin
          w_pc_nxt    = redirect_pc;
          w_addr_nxt  = redirect_pc;
          w_state_nxt = FETCH;
        end else if (!stall) begin
          w_pc_nxt    = r_pc + 64'd4;
          w_addr_nxt  = r_pc + 64'd4;
          w_state_nxt = FETCH;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_addr      <= '0;
      r_buf_pc    <= '0;
      r_buf_instr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_addr  <= w_addr_nxt;
      if (w_capture) begin
        r_buf_pc    <= r_pc;
        r_buf_instr <= ibus.iresp.data;
      end
    end
  end

  assign ibus.ireq = '{valid: (r_state == FETCH) || (r_state == DISCARD),
                       addr:  r_addr};
  assign f_valid   = (r_state == HOLD);
  assign f_pc      = r_buf_pc;
  assign f_instr   = r_buf_instr;

`ifdef FETCH_PERF_EN
  logic w_wait;
  assign w_wait = ((r_state == FETCH) || (r_state == DISCARD)) && !w_data_ok;

  fetch_perf u_perf (
    .clk         (clk),
    .reset       (reset),
    .i_inc_fetch (w_capture),
    .i_inc_wait  (w_wait),
    .o_fetch_cnt (perf_fetch_cnt),
    .o_wait_cnt  (perf_wait_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
// Self-checking bench for fetch_ctrl: directed scenarios followed by a
// randomized run checked against a transaction-level reference model.
// Perf counter checks are included when FETCH_PERF_EN is defined.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        f_valid;
  logic [63:0] f_pc;
  logic [31:0] f_instr;
`ifdef FETCH_PERF_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_wait_cnt;
`endif

  int total = 0;
  int bad   = 0;

  fetch_ctrl_if ibus();

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(RPC)) dut (
    .clk            (clk),
    .reset          (reset),
    .ibus           (ibus),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .f_valid        (f_valid),
    .f_pc           (f_pc),
    .f_instr        (f_instr)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_wait_cnt  (perf_wait_cnt)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0013;
  endfunction

  // Advances to the first negedge where a request is on the bus.
  task automatic wait_req(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ibus.ireq.valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    ibus.iresp = '0;
    repeat (3) @(negedge clk);
    total++; if (ibus.ireq.valid !== 1'b0) begin bad++; $display("FAIL reset_ireq_valid: got %b want 0", ibus.ireq.valid); end
    total++; if (ibus.ireq.addr !== 64'd0) begin bad++; $display("FAIL reset_ireq_addr: got %h want 0", ibus.ireq.addr); end
    total++; if (f_valid !== 1'b0) begin bad++; $display("FAIL reset_f_valid: got %b want 0", f_valid); end
    total++; if (f_pc !== 64'd0) begin bad++; $display("FAIL reset_f_pc: got %h want 0", f_pc); end
    total++; if (f_instr !== 32'd0) begin bad++; $display("FAIL reset_f_instr: got %h want 0", f_instr); end
`ifdef FETCH_PERF_EN
    total++; if (perf_fetch_cnt !== 64'd0 || perf_wait_cnt !== 64'd0) begin
      bad++; $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_fetch_cnt, perf_wait_cnt); end
`endif
    reset = 1'b1;
  endtask

  task automatic test_basic_fetch();
    bit seen;
    wait_req(seen);
    total++; if (!seen) begin bad++; $display("FAIL basic_req_timeout: got no request want request"); end
    total++; if (ibus.ireq.addr !== RPC) begin bad++; $display("FAIL basic_first_addr: got %h want %h", ibus.ireq.addr, RPC); end
    ibus.iresp.addr_ok = 1'b1;
    @(negedge clk);
    ibus.iresp.addr_ok = 1'b0;
    total++; if ({ibus.ireq.valid, ibus.ireq.addr} !== {1'b1, RPC}) begin
      bad++; $display("FAIL basic_hold_req1: got %b/%h want 1/%h", ibus.ireq.valid, ibus.ireq.addr, RPC); end
    @(negedge clk);
    total++; if ({ibus.ireq.valid, ibus.ireq.addr} !== {1'b1, RPC}) begin
      bad++; $display("FAIL basic_hold_req2: got %b/%h want 1/%h", ibus.ireq.valid, ibus.ireq.addr, RPC); end
    total++; if (f_valid !== 1'b0) begin bad++; $display("FAIL basic_fvalid_early: got %b want 0", f_valid); end
    ibus.iresp.data_ok = 1'b1;
    ibus.iresp.data = 32'h0000_0013;
    @(negedge clk);
    ibus.iresp.data_ok = 1'b0;
    stall = 1'b1;
    total++; if (f_valid !== 1'b1) begin bad++; $display("FAIL basic_fvalid: got %b want 1", f_valid); end
    total++; if (f_pc !== RPC) begin bad++; $display("FAIL basic_fpc: got %h want %h", f_pc, RPC); end
    total++; if (f_instr !== 32'h0000_0013) begin bad++; $display("FAIL basic_finstr: got %h want 00000013", f_instr); end
  endtask

  task automatic test_stall_hold();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if ({f_valid, f_pc, f_instr, ibus.ireq.valid} !== {1'b1, RPC, 32'h0000_0013, 1'b0}) begin
        bad++; $display("FAIL stall_hold_%0d: got fv=%b pc=%h in=%h rv=%b want 1/%h/00000013/0",
                        i, f_valid, f_pc, f_instr, ibus.ireq.valid, RPC); end
    end
    stall = 1'b0;
    @(negedge clk);
    total++; if ({ibus.ireq.valid, ibus.ireq.addr} !== {1'b1, RPC + 64'd4}) begin
      bad++; $display("FAIL stall_next_addr: got %b/%h want 1/%h", ibus.ireq.valid, ibus.ireq.addr, RPC + 64'd4); end
    ibus.iresp.data_ok = 1'b1;
    ibus.iresp.data = 32'h0010_0093;
    @(negedge clk);
    ibus.iresp.data_ok = 1'b0;
    total++; if ({f_valid, f_pc, f_instr} !== {1'b1, RPC + 64'd4, 32'h0010_0093}) begin
      bad++; $display("FAIL stall_second_instr: got %b/%h/%h want 1/%h/00100093", f_valid, f_pc, f_instr, RPC + 64'd4); end
    @(negedge clk);
    total++; if ({ibus.ireq.valid, ibus.ireq.addr} !== {1'b1, RPC + 64'd8}) begin
      bad++; $display("FAIL stall_third_addr: got %b/%h want 1/%h", ibus.ireq.valid, ibus.ireq.addr, RPC + 64'd8); end
  endtask

  task automatic test_redirect_fetch();
    redirect_valid = 1'b1;
    redirect_pc = RPC + 64'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++; if ({ibus.ireq.valid, ibus.ireq.addr, f_valid} !== {1'b1, RPC + 64'd8, 1'b0}) begin
        bad++; $display("FAIL redir_fetch_hold_%0d: got %b/%h fv=%b want 1/%h fv=0",
                        i, ibus.ireq.valid, ibus.ireq.addr, f_valid, RPC + 64'd8); end
      if (i == 0) @(negedge clk);
    end
    ibus.iresp.data_ok = 1'b1;
    ibus.iresp.data = 32'hDEAD_BEEF;
    @(negedge clk);
    ibus.iresp.data_ok = 1'b0;
    total++; if (f_valid !== 1'b0) begin bad++; $display("FAIL redir_fetch_leak: got %b want 0", f_valid); end
    total++; if ({ibus.ireq.valid, ibus.ireq.addr} !== {1'b1, RPC + 64'h100}) begin
      bad++; $display("FAIL redir_fetch_new_addr: got %b/%h want 1/%h", ibus.ireq.valid, ibus.ireq.addr, RPC + 64'h100); end
  endtask

  task automatic test_redirect_same_cycle();
    ibus.iresp.data_ok = 1'b1;
    ibus.iresp.data = 32'hBADB_AD00;
    redirect_valid = 1'b1;
    redirect_pc = RPC + 64'h200;
    @(negedge clk);
    ibus.iresp.data_ok = 1'b0;
    redirect_valid = 1'b0;
    total++; if (f_valid !== 1'b0) begin bad++; $display("FAIL redir_same_leak: got %b want 0", f_valid); end
    total++; if ({ibus.ireq.valid, ibus.ireq.addr} !== {1'b1, RPC + 64'h200}) begin
      bad++; $display("FAIL redir_same_addr: got %b/%h want 1/%h", ibus.ireq.valid, ibus.ireq.addr, RPC + 64'h200); end
    ibus.iresp.data_ok = 1'b1;
    ibus.iresp.data = 32'h0020_0093;
    @(negedge clk);
    ibus.iresp.data_ok = 1'b0;
    total++; if ({f_valid, f_pc, f_instr} !== {1'b1, RPC + 64'h200, 32'h0020_0093}) begin
      bad++; $display("FAIL redir_same_capture: got %b/%h/%h want 1/%h/00200093", f_valid, f_pc, f_instr, RPC + 64'h200); end
  endtask

  task automatic test_redirect_hold();
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = RPC + 64'h300;
    @(negedge clk);
    redirect_valid = 1'b0;
    stall = 1'b0;
    total++; if (f_valid !== 1'b0) begin bad++; $display("FAIL redir_hold_fvalid: got %b want 0", f_valid); end
    total++; if ({ibus.ireq.valid, ibus.ireq.addr} !== {1'b1, RPC + 64'h300}) begin
      bad++; $display("FAIL redir_hold_addr: got %b/%h want 1/%h", ibus.ireq.valid, ibus.ireq.addr, RPC + 64'h300); end
  endtask

  // Random traffic against a transaction-level model: the architectural
  // next-fetch PC, the one outstanding request, and which instruction (if
  // any) decode should see next cycle.
  task automatic test_random();
    bit          outst = 1'b0, clean = 1'b0, exp_fv = 1'b0, nfv, st, rd, dok;
    logic [63:0] exp_pc = RPC, req_addr = '0, exp_fpc = '0, rp;
    logic [31:0] exp_fi = '0;
    int          lat = 0;
    test_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      total++; if (f_valid !== exp_fv) begin bad++; $display("FAIL rnd_fvalid c=%0d: got %b want %b", c, f_valid, exp_fv); end
      if (exp_fv) begin
        total++; if ({f_pc, f_instr} !== {exp_fpc, exp_fi}) begin
          bad++; $display("FAIL rnd_fdata c=%0d: got %h/%h want %h/%h", c, f_pc, f_instr, exp_fpc, exp_fi); end
      end
      total++; if (ibus.ireq.valid !== !exp_fv) begin
        bad++; $display("FAIL rnd_req_valid c=%0d: got %b want %b", c, ibus.ireq.valid, !exp_fv); end
      if (outst) begin
        total++; if (ibus.ireq.addr !== req_addr) begin
          bad++; $display("FAIL rnd_addr_stable c=%0d: got %h want %h", c, ibus.ireq.addr, req_addr); end
      end else if (ibus.ireq.valid === 1'b1) begin
        total++; if (ibus.ireq.addr !== exp_pc) begin
          bad++; $display("FAIL rnd_req_addr c=%0d: got %h want %h", c, ibus.ireq.addr, exp_pc); end
        outst = 1'b1;
        clean = 1'b1;
        req_addr = ibus.ireq.addr;
        lat = $urandom_range(0, 3);
      end
      st = ($urandom_range(0, 2) == 0);
      rd = (outst || exp_fv) && ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) rp = 64'hFFFF_FFFF_FFFF_FFF8;
      else rp = {$urandom, $urandom} & ~64'h3;
      dok = outst && (lat == 0);
      if (outst && lat > 0) lat--;
      stall = st;
      redirect_valid = rd;
      redirect_pc = rp;
      ibus.iresp.addr_ok = 1'($urandom_range(0, 1));
      ibus.iresp.data_ok = dok;
      ibus.iresp.data = mem_word(req_addr);
      nfv = 1'b0;
      if (rd) begin
        exp_pc = rp;
        clean = 1'b0;
      end
      if (dok) begin
        outst = 1'b0;
        if (clean) begin
          nfv = 1'b1;
          exp_fpc = req_addr;
          exp_fi = mem_word(req_addr);
        end
      end else if (exp_fv && !rd) begin
        if (st) nfv = 1'b1;
        else exp_pc = exp_fpc + 64'd4;
      end
      exp_fv = nfv;
    end
    stall = 1'b0;
    redirect_valid = 1'b0;
    ibus.iresp = '0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    wait_req(seen);
    total++; if (!seen) begin bad++; $display("FAIL mid_req_timeout: got no request want request"); end
    reset = 1'b0;
    #1;
    total++; if ({ibus.ireq.valid, ibus.ireq.addr, f_valid, f_pc} !== {1'b0, 64'd0, 1'b0, 64'd0}) begin
      bad++; $display("FAIL mid_async_reset: got %b/%h fv=%b pc=%h want 0/0 fv=0 pc=0",
                      ibus.ireq.valid, ibus.ireq.addr, f_valid, f_pc); end
    @(negedge clk);
    reset = 1'b1;
    ibus.iresp.data_ok = 1'b1;
    ibus.iresp.data = 32'h0BAD_0BAD;
    @(negedge clk);
    ibus.iresp.data_ok = 1'b0;
    total++; if ({f_valid, ibus.ireq.valid, ibus.ireq.addr} !== {1'b0, 1'b1, RPC}) begin
      bad++; $display("FAIL mid_after_release: got fv=%b %b/%h want fv=0 1/%h", f_valid, ibus.ireq.valid, ibus.ireq.addr, RPC); end
    @(negedge clk);
    total++; if (f_valid !== 1'b0) begin bad++; $display("FAIL mid_stale_data: got %b want 0", f_valid); end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    bit seen;
    test_reset();
    for (int i = 0; i < 5; i++) begin
      wait_req(seen);
      total++; if (!seen) begin bad++; $display("FAIL perf_req_timeout_%0d: got no request want request", i); end
      repeat (2) @(negedge clk);
      ibus.iresp.data_ok = 1'b1;
      ibus.iresp.data = 32'h0000_0013;
      @(negedge clk);
      ibus.iresp.data_ok = 1'b0;
      if (i == 4) stall = 1'b1;
    end
    total++; if (perf_fetch_cnt !== 64'd5) begin bad++; $display("FAIL perf_fetch_cnt: got %0d want 5", perf_fetch_cnt); end
    total++; if (perf_wait_cnt !== 64'd10) begin bad++; $display("FAIL perf_wait_cnt: got %0d want 10", perf_wait_cnt); end
    stall = 1'b0;
  endtask
`endif

  initial begin
    ibus.iresp = '0;
    test_reset();
    test_basic_fetch();
    test_stall_hold();
    test_redirect_fetch();
    test_redirect_same_cycle();
    test_redirect_hold();
    test_random();
    test_reset_mid();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 clk  input  1  core clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 ireq  output  ibus_req_t  instruction bus request (valid, addr).
REQ-005 iresp  input  ibus_resp_t  instruction bus response (addr_ok, data_ok, data[31:0]).
REQ-006 stall  input  1  decode not ready; buffered instruction not consumed this cycle.
REQ-007 redirect_valid  input  1  branch/jump redirect from execute, single-cycle pulse.
REQ-008 redirect_pc  input  64  redirect target, 4-byte aligned.
REQ-009 f_valid  output  1  f_pc/f_instr hold a valid fetched instruction.
REQ-010 f_pc  output  64  PC of buffered instruction.
REQ-011 f_instr  output  32  buffered instruction word.

Function
REQ-012 States IDLE, FETCH, DISCARD, HOLD; reset state IDLE; IDLE -> FETCH unconditionally next cycle.
REQ-013 FETCH: ireq.valid=1, ireq.addr=pc; addr held stable and valid never dropped until data_ok, regardless of addr_ok timing (addr_ok and data_ok may arrive same cycle).
REQ-014 FETCH, data_ok=1, no redirect: capture {pc, data} into buffer, -> HOLD; f_valid=1 from next cycle (1-cycle latency data_ok -> f_valid).
REQ-015 FETCH, redirect_valid=1 before data_ok: pc <= redirect_pc, -> DISCARD; ireq.valid stays 1 with old addr.
REQ-016 FETCH, redirect_valid=1 in same cycle as data_ok: response discarded, pc <= redirect_pc, -> FETCH (new request next cycle).
REQ-017 DISCARD: ireq.valid=1 with in-flight addr; on data_ok drop data, -> FETCH with redirected pc; further redirect in DISCARD overwrites pc, stays DISCARD.
REQ-018 HOLD: f_valid=1, ireq.valid=0; stall=0 -> pc <= pc+4 (64-bit wrap), -> FETCH.
REQ-019 HOLD, redirect_valid=1 (any stall value): buffer invalidated, f_valid=0 next cycle, pc <= redirect_pc, -> FETCH; redirect takes priority over consume.
REQ-020 f_valid=0 in IDLE, FETCH, DISCARD; f_pc/f_instr hold last captured values.
REQ-021 Discarded responses never appear on f_valid.

Reset
REQ-022 While reset=0: state=IDLE, pc=RESET_PC, ireq.valid=0, ireq.addr=0, f_valid=0, f_pc=0, f_instr=0, perf counters=0.
REQ-023 Reset asserted mid-transaction abandons it; outstanding data_ok after reset release is ignored unless state is FETCH/DISCARD.

Configuration
REQ-024 Macro FETCH_PERF_EN defined: output ports perf_fetch_cnt (64) counting instructions entering HOLD and perf_wait_cnt (64) counting cycles in FETCH/DISCARD without data_ok; both saturate at all-ones.
REQ-025 FETCH_PERF_EN undefined: ports and counters absent; all other behaviour identical.

Structure
REQ-026 fetch_state_t enum and RESET_PC default constant live in the shared common package; ibus_req_t/ibus_resp_t reused from common.
REQ-027 Single sub-module fetch_perf (counters), instantiated only under FETCH_PERF_EN; state machine flat in fetch_ctrl.

Verification
REQ-028 Reset release, iresp data_ok 2 cycles after ireq.valid with data 32'h0000_0013 -> first ireq.addr=64'h8000_0000; f_valid=1, f_pc=64'h8000_0000, f_instr=32'h0000_0013 one cycle after data_ok.
REQ-029 stall=1 for 3 cycles in HOLD -> f_valid/f_pc/f_instr stable, ireq.valid=0; stall=0 -> next ireq.addr=64'h8000_0004.
REQ-030 redirect_valid=1, redirect_pc=64'h8000_0100 while FETCH awaiting data_ok at 64'h8000_0008 -> addr stays 64'h8000_0008 until data_ok, data never visible, next ireq.addr=64'h8000_0100.
REQ-031 redirect in same cycle as data_ok -> no f_valid for that data; next request addr=redirect_pc.
REQ-032 redirect in HOLD with stall=1 -> f_valid=0 next cycle, next ireq.addr=redirect_pc.
REQ-033 With FETCH_PERF_EN, 5 instructions each with 2 wait cycles -> perf_fetch_cnt=5, perf_wait_cnt=10.
